mc_control_fsm: RTL

Multicycle control sequencer for the RV32I datapath: decodes the latched instruction's opcode/funct fields and steps through fetch, decode, execute, memory and writeback states. It drives the datapath muxes, the write enables and `imm_src` for the immediate extender, and stalls on a single memory-ready handshake. It sits between the instruction register and the shared PC/ALU/memory datapath.

---
 rtl/riscv_ctrl_pkg.sv | 79 +++++++
 rtl/ctrl_out_dec.sv | 99 +++++++++
 rtl/mc_control_fsm.sv | 103 ++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the RV32I multicycle control path.
// Holds the sequencer state enum, the opcode constants it decodes, and the
// imm_src / alu_op / result_src / alu_src_a / alu_src_b encodings. The
// immediate extender and the ALU decoder import the same constants.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_U,
        S_JAL,
        S_ALUWB,
        S_BRANCH,
        S_TRAP
    } state_t;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_U = 3'b101;

    // ALU operation class
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Result mux
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ALU A operand
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU B operand
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Decoded control word driven to the datapath
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [2:0] imm_src;
    } ctrl_t;

endpackage

// File: rtl/ctrl_out_dec.sv
// ctrl_out_dec: combinational state -> control-word decode.
// Ports:
//   state      in  current sequencer state
//   opcode     in  latched instr[6:0] (selects imm format / A source)
//   funct3     in  latched instr[14:12] (branch condition)
//   zero       in  ALU zero flag (branch decision)
//   mem_ready  in  memory handshake (fetch completes the IR/PC load)
//   ctrl       out datapath control word; unlisted fields are 0
module ctrl_out_dec
    import riscv_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic        mem_ready,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALURES;
                // PC+4 and the IR load only commit once memory returns data
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
            end
            S_DECODE: begin
                // Speculatively form the branch/jump target into ALUOut
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                ctrl.imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_RDATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = IMM_I;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_EXEC_U: begin
                // lui adds the immediate to zero, auipc to the old PC
                ctrl.alu_src_a = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = IMM_U;
                ctrl.alu_op    = ALU_ADD;
            end
            S_JAL: begin
                // Jump target already sits in ALUOut; ALU forms old PC + 4 for rd
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALU_SUB;
                ctrl.result_src = RES_ALUOUT;
                if (funct3 == F3_BEQ)
                    ctrl.pc_write = zero;
                else if (funct3 == F3_BNE)
                    ctrl.pc_write = ~zero;
            end
            default: ;  // S_TRAP: everything inactive
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32I control sequencer.
// Steps fetch/decode/execute/memory/writeback from the latched opcode and
// funct3, stalling in FETCH, MEMREAD and MEMWRITE until mem_ready.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   opcode, funct3         latched instruction fields
//   zero                   ALU zero flag (branches)
//   mem_ready              memory access completes this cycle
//   pc_write, ir_write,
//   mem_write, reg_write   write enables (forced low while in reset)
//   adr_src, result_src,
//   alu_src_a, alu_src_b,
//   alu_op, imm_src        datapath mux / ALU / immediate selects
//   illegal                sticky unsupported-instruction flag
module mc_control_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal
);

    state_t state, state_n;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_n;
    end

    // Set on the edge that enters TRAP, so it reads 1 throughout TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 illegal <= 1'b0;
        else if (state_n == S_TRAP) illegal <= 1'b1;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:    if (mem_ready) state_n = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_n = S_MEMADR;
                    OP_R:              state_n = S_EXEC_R;
                    OP_I:              state_n = S_EXEC_I;
                    OP_BRANCH:         state_n = S_BRANCH;
                    OP_JAL:            state_n = S_JAL;
                    OP_LUI, OP_AUIPC:  state_n = S_EXEC_U;
                    default:           state_n = S_TRAP;
                endcase
            end
            S_MEMADR:   state_n = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_n = S_MEMWB;
            S_MEMWB:    state_n = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_n = S_FETCH;
            S_EXEC_R,
            S_EXEC_I,
            S_EXEC_U,
            S_JAL:      state_n = S_ALUWB;
            S_ALUWB:    state_n = S_FETCH;
            S_BRANCH:   state_n = (funct3 == F3_BEQ || funct3 == F3_BNE) ? S_FETCH : S_TRAP;
            S_TRAP:     state_n = S_TRAP;
            default:    state_n = S_TRAP;
        endcase
    end

    ctrl_out_dec u_dec (
        .state     (state),
        .opcode    (opcode),
        .funct3    (funct3),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // State resets to FETCH, whose enables follow mem_ready; gate them with
    // rst_n so nothing is written while reset is held.
    assign pc_write   = ctrl.pc_write  & rst_n;
    assign ir_write   = ctrl.ir_write  & rst_n;
    assign mem_write  = ctrl.mem_write & rst_n;
    assign reg_write  = ctrl.reg_write & rst_n;
    assign adr_src    = ctrl.adr_src;
    assign result_src = ctrl.result_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign imm_src    = ctrl.imm_src;

endmodule
